// File: rtl/pipelined_adder_nbit.sv
// Pipelined two's-complement adder/subtractor with a valid/ready stream interface.
// The carry chain is cut into STAGES chunks of CW bits. Operand chunks are skewed in
// so each meets the registered carry of the chunk below it, and finished sum chunks
// are de-skewed so all bits of one result leave together with c_out and ovf.
module pipelined_adder_nbit #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int unsigned CW = WIDTH / STAGES;

    logic              stall;
    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;
    logic              last_in_vld;  // valid bit of the slot about to enter the final stage
    logic              load_out;     // final-stage registers capture a real result
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] co_d;         // carry out of each chunk adder
    logic [STAGES-1:0] cy_q, cy_d;   // registered chunk carries; the top bit is c_out
    logic              ovf_d, ovf_q;

    assign stall     = vld_q[STAGES-1] & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = vld_q[STAGES-1];
    assign c_out     = cy_q[STAGES-1];
    assign ovf       = ovf_q;

    // Subtract is a + ~b + 1; c_in is ignored in that mode.
    assign b_eff   = op ? ~b : b;
    assign cin_eff = op | c_in;

    if (STAGES == 1) begin : g_single
        assign last_in_vld = in_valid;
    end else begin : g_multi
        assign last_in_vld = vld_q[STAGES-2];
    end

    // Bubbles do not touch the output registers, so outputs hold their last result.
    assign load_out = ~stall & last_in_vld;

    // Next state of the valid shift chain and the chunk carry registers.
    always_comb begin
        vld_d = vld_q;
        cy_d  = cy_q;
        if (!stall) begin
            vld_d[0] = in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld_d[k] = vld_q[k-1];
            end
            for (int k = 0; k + 1 < STAGES; k++) begin
                cy_d[k] = co_d[k];
            end
        end
        if (load_out) begin
            cy_d[STAGES-1] = co_d[STAGES-1];
        end
    end

    // Control and flag state; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            cy_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            if (load_out) begin
                ovf_q <= ovf_d;
            end
        end
    end

    for (genvar j = 0; j < STAGES; j++) begin : g_chunk
        logic [CW-1:0] a_in;
        logic [CW-1:0] b_in;
        logic [CW-1:0] s_new;
        logic          cy_in;

        if (j == 0) begin : g_head
            assign a_in  = a[CW-1:0];
            assign b_in  = b_eff[CW-1:0];
            assign cy_in = cin_eff;
        end else begin : g_skew
            logic [CW-1:0] a_q [j];
            logic [CW-1:0] b_q [j];

            // Delay operand chunk j by j slots so it meets the carry from chunk j-1.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < j; i++) begin
                        a_q[i] <= '0;
                        b_q[i] <= '0;
                    end
                end else if (!stall) begin
                    a_q[0] <= a[j*CW +: CW];
                    b_q[0] <= b_eff[j*CW +: CW];
                    for (int i = 1; i < j; i++) begin
                        a_q[i] <= a_q[i-1];
                        b_q[i] <= b_q[i-1];
                    end
                end
            end

            assign a_in  = a_q[j-1];
            assign b_in  = b_q[j-1];
            assign cy_in = cy_q[j-1];
        end

        assign {co_d[j], s_new} = {1'b0, a_in} + {1'b0, b_in} + {{CW{1'b0}}, cy_in};

        if (j == STAGES - 1) begin : g_msb
            logic [CW-1:0] s_q;

            // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
            assign ovf_d = co_d[j] ^ (s_new[CW-1] ^ a_in[CW-1] ^ b_in[CW-1]);

            // Top sum chunk is computed in the last stage and goes straight to the output.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s_q <= '0;
                end else if (load_out) begin
                    s_q <= s_new;
                end
            end

            assign sum[j*CW +: CW] = s_q;
        end else begin : g_deskew
            localparam int unsigned Depth = STAGES - j;
            logic [CW-1:0] s_q [Depth];

            // Hold finished chunk j until the upper chunks catch up; last slot is the output.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < Depth; i++) begin
                        s_q[i] <= '0;
                    end
                end else begin
                    if (!stall) begin
                        s_q[0] <= s_new;
                        for (int i = 1; i + 1 < Depth; i++) begin
                            s_q[i] <= s_q[i-1];
                        end
                    end
                    if (load_out) begin
                        s_q[Depth-1] <= s_q[Depth-2];
                    end
                end
            end

            assign sum[j*CW +: CW] = s_q[Depth-1];
        end
    end

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Self-checking bench for pipelined_adder_nbit: directed vectors, streaming with
// backpressure, mid-flight reset, exhaustive 4-bit adds and an 8-bit parameter sweep.
module tb_pipelined_adder_nbit;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, sum;
    logic        c_in, op, c_out, ovf;

    int n_tests;
    int n_fail;

    pipelined_adder_nbit #(.WIDTH(16), .STAGES(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    // 4-bit instances: index 0 -> STAGES=1, index 1 -> STAGES=4
    logic       v4_in;
    logic [3:0] a4, b4;
    logic       cin4;
    logic       rdy4 [2];
    logic       v4 [2];
    logic [3:0] s4 [2];
    logic       c4 [2];
    logic       o4 [2];

    for (genvar g = 0; g < 2; g++) begin : g_w4
        pipelined_adder_nbit #(.WIDTH(4), .STAGES(g == 0 ? 1 : 4)) u_dut4 (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (v4_in),
            .in_ready  (rdy4[g]),
            .a         (a4),
            .b         (b4),
            .c_in      (cin4),
            .op        (1'b0),
            .out_valid (v4[g]),
            .out_ready (1'b1),
            .sum       (s4[g]),
            .c_out     (c4[g]),
            .ovf       (o4[g])
        );
    end

    // 8-bit instances with STAGES = 1, 2, 4, 8
    logic       v8_in;
    logic [7:0] a8, b8;
    logic       cin8, op8;
    logic       rdy8 [4];
    logic       v8 [4];
    logic [7:0] s8 [4];
    logic       c8 [4];
    logic       o8 [4];

    for (genvar g = 0; g < 4; g++) begin : g_w8
        pipelined_adder_nbit #(.WIDTH(8), .STAGES(1 << g)) u_dut8 (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (v8_in),
            .in_ready  (rdy8[g]),
            .a         (a8),
            .b         (b8),
            .c_in      (cin8),
            .op        (op8),
            .out_valid (v8[g]),
            .out_ready (1'b1),
            .sum       (s8[g]),
            .c_out     (c8[g]),
            .ovf       (o8[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Integer reference: returns {ovf, c_out, sum} for a w-bit operation.
    function automatic logic [33:0] ref_op(input int w, input logic [31:0] x,
                                           input logic [31:0] y, input logic ci,
                                           input logic o);
        longint m, xa, yb, c, u, sx, sy, t, lim;
        logic [31:0] s;
        logic co, ov;
        m   = (longint'(1) << w) - 1;
        xa  = longint'(x) & m;
        yb  = o ? (~longint'(y)) & m : longint'(y) & m;
        c   = (o || ci) ? 1 : 0;
        u   = xa + yb + c;
        sx  = ((xa >> (w - 1)) & 1) != 0 ? xa - (m + 1) : xa;
        sy  = ((yb >> (w - 1)) & 1) != 0 ? yb - (m + 1) : yb;
        t   = sx + sy + c;
        lim = (m + 1) >> 1;
        s   = 32'(u & m);
        co  = ((u >> w) & 1) != 0;
        ov  = (t >= lim) || (t < -lim);
        return {ov, co, s};
    endfunction

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        op;
        logic [15:0] sum;
        logic        co;
        logic        ov;
    } vec_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        op;
    } op_t;

    vec_t        vecs [10];
    op_t         ops [20];
    int          acc_cyc [20];
    logic [7:0]  sa8 [1000];
    logic [7:0]  sb8 [1000];
    logic        sc8 [1000];
    logic        so8 [1000];

    initial begin
        logic [15:0] prev;
        logic [33:0] r;
        int sent, got, last_seen;
        bit seen;

        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[7] = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[9] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0; op = 1'b0;
        v4_in = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        v8_in = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; op8 = 1'b0;
        step();
        step();
        rst = 1'b0;

        chk("reset out_valid", out_valid, 0);
        chk("reset sum", sum, 0);
        chk("reset c_out", c_out, 0);
        chk("reset ovf", ovf, 0);
        chk("reset in_ready", in_ready, 1);

        // Directed vectors, one at a time: latency and hold-while-idle
        prev = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a = vecs[i].a; b = vecs[i].b; c_in = vecs[i].cin; op = vecs[i].op;
            step();
            in_valid = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                if (k < 4) begin
                    chk($sformatf("vec%0d early out_valid", i), out_valid, 0);
                    chk($sformatf("vec%0d held sum", i), sum, prev);
                    step();
                end else begin
                    chk($sformatf("vec%0d out_valid", i), out_valid, 1);
                    chk($sformatf("vec%0d sum", i), sum, vecs[i].sum);
                    chk($sformatf("vec%0d c_out", i), c_out, vecs[i].co);
                    chk($sformatf("vec%0d ovf", i), ovf, vecs[i].ov);
                end
            end
            prev = vecs[i].sum;
        end
        step();

        // Back-to-back stream with out_ready low on cycles 6..8
        for (int i = 0; i < 20; i++) begin
            ops[i] = '{16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom)};
            acc_cyc[i] = 0;
        end
        sent = 0; got = 0; seen = 0; last_seen = -1;
        for (int cyc = 0; cyc < 40 && got < 20; cyc++) begin
            in_valid = (sent < 20);
            if (sent < 20) begin
                a = ops[sent].a; b = ops[sent].b; c_in = ops[sent].cin; op = ops[sent].op;
            end
            out_ready = !(cyc >= 6 && cyc <= 8);
            #1;
            chk($sformatf("stream in_ready c%0d", cyc), in_ready, !(cyc >= 6 && cyc <= 8));
            if (out_valid) begin
                if (got < sent) begin
                    r = ref_op(16, ops[got].a, ops[got].b, ops[got].cin, ops[got].op);
                    chk($sformatf("stream sum #%0d", got), sum, r[15:0]);
                    chk($sformatf("stream c_out #%0d", got), c_out, r[32]);
                    chk($sformatf("stream ovf #%0d", got), ovf, r[33]);
                    if (!seen) begin
                        seen = 1;
                        chk($sformatf("stream latency #%0d", got), (cyc >= acc_cyc[got] + 4), 1);
                    end
                    if (out_ready) begin
                        last_seen = cyc;
                        got++;
                        seen = 0;
                    end
                end else begin
                    chk("stream unexpected result", 1, 0);
                end
            end
            if (in_valid && !(cyc >= 6 && cyc <= 8)) begin
                acc_cyc[sent] = cyc;
                sent++;
            end
            step();
        end
        chk("stream result count", got, 20);
        chk("stream last arrival cycle", last_seen, 26);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 16'(16'h1111 * (i + 1)); b = 16'h0101; c_in = 1'b0; op = 1'b0;
            step();
        end
        rst = 1'b1; a = 16'h0F0F; b = 16'h0101;
        step();
        rst = 1'b0;
        a = 16'h2222; b = 16'h1111; c_in = 1'b1; op = 1'b0;
        chk("midrst out_valid", out_valid, 0);
        chk("midrst sum", sum, 0);
        chk("midrst c_out", c_out, 0);
        chk("midrst ovf", ovf, 0);
        chk("midrst in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) begin
                chk("midrst discarded out_valid", out_valid, 0);
                step();
            end else begin
                chk("midrst new out_valid", out_valid, 1);
                chk("midrst new sum", sum, 16'h3334);
                chk("midrst new c_out", c_out, 0);
            end
        end
        for (int k = 0; k < 6; k++) begin
            step();
            chk("midrst no ghost result", out_valid, 0);
        end

        // Exhaustive 4-bit adds against STAGES=1 and STAGES=4
        for (int c = 0; c < 512 + 6; c++) begin
            v4_in = (c < 512);
            {cin4, b4, a4} = 9'(c);
            #1;
            for (int g = 0; g < 2; g++) begin
                int st, k, ea, eb, ec;
                st = (g == 0) ? 1 : 4;
                if (c >= st && c - st < 512) begin
                    k  = c - st;
                    ea = k & 15;
                    eb = (k >> 4) & 15;
                    ec = (k >> 8) & 1;
                    chk($sformatf("w4 S%0d out_valid", st), v4[g], 1);
                    chk($sformatf("w4 S%0d result k=%0d", st, k), {c4[g], s4[g]}, ea + eb + ec);
                end else begin
                    chk($sformatf("w4 S%0d idle out_valid", st), v4[g], 0);
                end
            end
            step();
        end
        v4_in = 1'b0;

        // 8-bit sweep, random add/subtract, all four stage counts in parallel
        for (int i = 0; i < 1000; i++) begin
            sa8[i] = 8'($urandom);
            sb8[i] = 8'($urandom);
            sc8[i] = 1'($urandom);
            so8[i] = 1'($urandom);
        end
        for (int c = 0; c < 1000 + 10; c++) begin
            v8_in = (c < 1000);
            if (c < 1000) begin
                a8 = sa8[c]; b8 = sb8[c]; cin8 = sc8[c]; op8 = so8[c];
            end
            #1;
            for (int g = 0; g < 4; g++) begin
                int st, k;
                st = 1 << g;
                if (c >= st && c - st < 1000) begin
                    k = c - st;
                    r = ref_op(8, 32'(sa8[k]), 32'(sb8[k]), sc8[k], so8[k]);
                    chk($sformatf("w8 S%0d out_valid", st), v8[g], 1);
                    chk($sformatf("w8 S%0d result k=%0d", st, k), {o8[g], c8[g], s8[g]},
                        {r[33], r[32], r[7:0]});
                end else begin
                    chk($sformatf("w8 S%0d idle out_valid", st), v8[g], 0);
                end
            end
            step();
        end
        v8_in = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
